pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the CPU fetch stage, replacing the plain PC register. It holds the current fetch address and each cycle selects the next one from reset, trap, return, call, branch/jump redirect, stall or sequential increment. It optionally includes a small return-address stack (RAS) for call/return prediction. Its output drives instruction-memory addressing and the fetch/decode pipeline register.

## Interface

**Parameters**
- `WIDTH`, 32: PC width in bits.
- `RESET_VEC`, 0: PC value loaded on reset.
- `TRAP_VEC`, 32'h100: PC value loaded on trap.
- `STEP`, 4: sequential increment. Must be a power of two and at least 2.
- `RAS_DEPTH`, 4: RAS entries. Must be at least 2. Used only with `PC_RAS_EN`.

**Ports**
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `stall` in 1: hold the PC. Ignored when any redirect is asserted.
- `trap` in 1: redirect to `TRAP_VEC`.
- `redir` in 1: branch/jump redirect to `redir_tgt`.
- `call` in 1: redirect to `redir_tgt` and push `pc_plus`.
- `ret` in 1: redirect to the popped RAS entry.
- `redir_tgt` in WIDTH: target for `redir`, `call` and RAS-empty `ret`.
- `pc` out WIDTH: current PC, registered.
- `pc_plus` out WIDTH: `pc + STEP`, combinational, modulo 2^WIDTH.
- `misalign` out 1: registered. High for one cycle when the current `pc` came from a misaligned target.
- `ras_empty` out 1: RAS holds no entries.
- `ras_full` out 1: RAS holds `RAS_DEPTH` entries.

## Operation

**Next-PC priority (highest first)**
1. `trap`: next PC is `TRAP_VEC`.
2. `ret`: next PC is the RAS top, or `redir_tgt` if the RAS is empty.
3. `call`: next PC is `redir_tgt`.
4. `redir`: next PC is `redir_tgt`.
5. `stall`: next PC is `pc` (hold).
6. Otherwise: next PC is `pc_plus`.

**Alignment**
- Every target from `redir_tgt` has its low log2(`STEP`) bits forced to 0 before loading.
- `misalign` is 1 in the cycle after such a load if any of those low bits were nonzero. Otherwise it is 0.
- `TRAP_VEC`, `RESET_VEC` and RAS entries are not checked.

**Increment**
- `pc_plus` wraps: 0xFFFF_FFFC + 4 gives 0x0000_0000, with no flag.

**RAS**
- Circular LIFO with a top pointer and a count in the range 0..`RAS_DEPTH`.
- Push (`call` acts): write `pc_plus` to the next slot and increment the count.
  - Push when full: overwrite the oldest entry. The count stays at `RAS_DEPTH` and `ras_full` stays 1.
- Pop (`ret` acts with count > 0): read the top entry and decrement the count.
- Pop when empty: no stack change. The PC takes `redir_tgt`.
- `call` and `ret` in the same cycle: the PC follows `ret`, and the top entry is replaced by `pc_plus`. The count is unchanged; if the RAS was empty, it becomes 1.
- `trap` asserted: no RAS operation occurs, even if `call` or `ret` are also high.
- `stall` has no effect on RAS operations.

## Timing

- All state updates on the rising edge of `clk`. A request sampled in cycle N appears on `pc` in cycle N+1.
- Reset, asynchronous on `rst` high:
  - `pc` = `RESET_VEC`, `misalign` = 0.
  - RAS count = 0, so `ras_empty` = 1 and `ras_full` = 0.
- Reset mid-operation discards all RAS contents and any redirect in flight.
- The first increment occurs on the first rising edge after `rst` deasserts, unless `stall` is high.
- `ras_empty` and `ras_full` are decoded from the registered count, so they change in the cycle after the push or pop.
- RAS top-entry read is combinational, giving a single-cycle return.

## Configuration

- Macro `PC_RAS_EN` defined: RAS storage and logic are compiled in, as described above.
- Macro not defined:
  - No RAS storage.
  - `ret` and `call` each behave as `redir` (target `redir_tgt`), keeping the same priority order.
  - `ras_empty` is tied to 1 and `ras_full` to 0.
  - `RAS_DEPTH` is unused.

## Test plan

1. Reset (`RESET_VEC`=0), then 3 free cycles: `pc` = 0, 4, 8, 12. Assert `stall` for 2 cycles: `pc` holds 12. Release: `pc` = 16.
2. `stall`=1 together with `redir`=1, `redir_tgt`=0x40: next `pc` = 0x40 (redirect beats stall). Then `redir_tgt`=0x42: `pc` = 0x40 and `misalign` = 1 for exactly one cycle.
3. `trap`, `redir` and `call` together: `pc` = 0x100 and the RAS count is unchanged. Assert `rst` asynchronously mid-cycle: `pc` = 0 immediately and `ras_empty` = 1.
4. With `PC_RAS_EN`: at `pc`=0x10, `call` with `redir_tgt`=0x80: `pc` = 0x80 and `ras_empty` = 0. Then `ret`: `pc` = 0x14 and `ras_empty` = 1.
5. With `PC_RAS_EN`, `RAS_DEPTH`=4: 5 nested calls give `ras_full` = 1. Rets 1–4 return the last four return addresses in LIFO order. Ret 5 (RAS empty) with `redir_tgt`=0x200: `pc` = 0x200.
6. Without `PC_RAS_EN`: `ret` with `redir_tgt`=0x60 gives `pc` = 0x60, with `ras_empty`=1 and `ras_full`=0 throughout.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with next-PC select; `PC_RAS_EN adds a return-address stack
module pc_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC = 'h100,
  parameter int STEP = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             trap,
  input  logic             redir,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] redir_tgt,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             misalign,
  output logic             ras_empty,
  output logic             ras_full
);
  localparam logic [WIDTH-1:0] MASK = WIDTH'(STEP - 1);
  logic [WIDTH-1:0] tgt_al, ras_top, pc_nxt;
  logic ras_hit, use_tgt;
  assign pc_plus = pc + WIDTH'(STEP);
  assign tgt_al = redir_tgt & ~MASK;
`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] top, top_inc, top_dec;
  logic [CW-1:0] cnt;
  logic push, pop, repl;
  assign ras_empty = cnt == '0;
  assign ras_full = cnt == CW'(RAS_DEPTH);
  assign ras_top = ras[top];
  assign ras_hit = ret && !ras_empty;
  assign use_tgt = !trap && (ret ? ras_empty : (call || redir));
  assign top_inc = (top == PW'(RAS_DEPTH - 1)) ? '0 : top + 1'b1;
  assign top_dec = (top == '0) ? PW'(RAS_DEPTH - 1) : top - 1'b1;
  assign push = !trap && call && !ret;
  assign pop = !trap && ret && !call && !ras_empty;
  assign repl = !trap && call && ret;
  // stack pointer and occupancy; a full push wraps onto the oldest slot
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      top <= '0;
      cnt <= '0;
    end else begin
      top <= push ? top_inc : pop ? top_dec : top;
      cnt <= push ? (ras_full ? cnt : cnt + 1'b1) : pop ? cnt - 1'b1 : (repl && ras_empty) ? CW'(1) : cnt;
    end
  // entry storage: push writes the next slot, call+ret rewrites the top in place
  always_ff @(posedge clk)
    if (push) ras[top_inc] <= pc_plus;
    else if (repl) ras[top] <= pc_plus;
`else
  assign ras_empty = 1'b1;
  assign ras_full = 1'b0;
  assign ras_top = '0;
  assign ras_hit = 1'b0;
  assign use_tgt = !trap && (ret || call || redir);
`endif
  assign pc_nxt = trap ? TRAP_VEC : ras_hit ? ras_top : use_tgt ? tgt_al : stall ? pc : pc_plus;
  // PC register; misalign flags a truncated redir_tgt load for one cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_VEC;
      misalign <= 1'b0;
    end else begin
      pc <= pc_nxt;
      misalign <= use_tgt && |(redir_tgt & MASK);
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit (RAS scenarios under PC_RAS_EN)
module tb_pc_unit;
  logic clk = 0, rst = 1, stall = 0, trap = 0, redir = 0, call = 0, ret = 0;
  logic [31:0] redir_tgt = '0, pc, pc_plus;
  logic misalign, ras_empty, ras_full;
  int total = 0, passed = 0;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .trap(trap), .redir(redir), .call(call), .ret(ret),
    .redir_tgt(redir_tgt), .pc(pc), .pc_plus(pc_plus), .misalign(misalign),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, t, r, c, rt, input logic [31:0] tgt);
    stall = s; trap = t; redir = r; call = c; ret = rt; redir_tgt = tgt;
  endtask

  task automatic test_reset;
    rst = 1;
    tick();
    total++; if (pc !== 32'h0) $display("FAIL reset_pc got %h want %h", pc, 32'h0); else passed++;
    total++; if (misalign !== 1'b0) $display("FAIL reset_misalign got %b want 0", misalign); else passed++;
    total++; if (ras_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", ras_empty); else passed++;
    total++; if (ras_full !== 1'b0) $display("FAIL reset_full got %b want 0", ras_full); else passed++;
    rst = 0;
  endtask

  task automatic test_increment;
    logic [31:0] exp_seq [3] = '{32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc !== exp_seq[i]) $display("FAIL incr_%0d got %h want %h", i, pc, exp_seq[i]); else passed++;
    end
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (pc !== 32'hC) $display("FAIL stall_%0d got %h want %h", i, pc, 32'hC); else passed++;
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++; if (pc !== 32'h10) $display("FAIL stall_release got %h want %h", pc, 32'h10); else passed++;
  endtask

  task automatic test_redirect;
    drive(1, 0, 1, 0, 0, 32'h40);
    tick();
    total++; if (pc !== 32'h40) $display("FAIL redir_over_stall got %h want %h", pc, 32'h40); else passed++;
    total++; if (misalign !== 1'b0) $display("FAIL redir_aligned_flag got %b want 0", misalign); else passed++;
    drive(1, 0, 1, 0, 0, 32'h42);
    tick();
    total++; if (pc !== 32'h40) $display("FAIL redir_misaligned got %h want %h", pc, 32'h40); else passed++;
    total++; if (misalign !== 1'b1) $display("FAIL misalign_set got %b want 1", misalign); else passed++;
    drive(0, 0, 0, 0, 0, 32'h42);
    tick();
    total++; if (pc !== 32'h44) $display("FAIL after_misalign got %h want %h", pc, 32'h44); else passed++;
    total++; if (misalign !== 1'b0) $display("FAIL misalign_one_cycle got %b want 0", misalign); else passed++;
  endtask

  task automatic test_wrap;
    drive(0, 0, 1, 0, 0, 32'hFFFF_FFFF);
    tick();
    total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_load got %h want %h", pc, 32'hFFFF_FFFC); else passed++;
    total++; if (pc_plus !== 32'h0) $display("FAIL wrap_pc_plus got %h want %h", pc_plus, 32'h0); else passed++;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++; if (pc !== 32'h0) $display("FAIL wrap_pc got %h want %h", pc, 32'h0); else passed++;
  endtask

  task automatic test_trap;
    drive(0, 1, 1, 1, 0, 32'h80);
    tick();
    total++; if (pc !== 32'h100) $display("FAIL trap_pc got %h want %h", pc, 32'h100); else passed++;
    total++; if (ras_empty !== 1'b1) $display("FAIL trap_no_push got %b want 1", ras_empty); else passed++;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++; if (pc !== 32'h104) $display("FAIL post_trap got %h want %h", pc, 32'h104); else passed++;
    #2 rst = 1;
    #1;
    total++; if (pc !== 32'h0) $display("FAIL async_rst_pc got %h want %h", pc, 32'h0); else passed++;
    total++; if (ras_empty !== 1'b1) $display("FAIL async_rst_empty got %b want 1", ras_empty); else passed++;
    tick();
    rst = 0;
  endtask

`ifdef PC_RAS_EN
  task automatic test_ras;
    logic [31:0] exp_ret [4] = '{32'h4004, 32'h3004, 32'h2004, 32'h1004};
    drive(0, 0, 1, 0, 0, 32'h10);
    tick();
    drive(0, 0, 0, 1, 0, 32'h80);
    tick();
    total++; if (pc !== 32'h80) $display("FAIL call_pc got %h want %h", pc, 32'h80); else passed++;
    total++; if (ras_empty !== 1'b0) $display("FAIL call_empty got %b want 0", ras_empty); else passed++;
    drive(0, 0, 0, 0, 1, 32'h0);
    tick();
    total++; if (pc !== 32'h14) $display("FAIL ret_pc got %h want %h", pc, 32'h14); else passed++;
    total++; if (ras_empty !== 1'b1) $display("FAIL ret_empty got %b want 1", ras_empty); else passed++;
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 0, 1, 0, 32'(i) << 12);
      tick();
    end
    total++; if (pc !== 32'h5000) $display("FAIL nest_pc got %h want %h", pc, 32'h5000); else passed++;
    total++; if (ras_full !== 1'b1) $display("FAIL nest_full got %b want 1", ras_full); else passed++;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 32'h0);
      tick();
      total++; if (pc !== exp_ret[i]) $display("FAIL lifo_%0d got %h want %h", i, pc, exp_ret[i]); else passed++;
    end
    total++; if (ras_empty !== 1'b1) $display("FAIL drained_empty got %b want 1", ras_empty); else passed++;
    drive(0, 0, 0, 0, 1, 32'h200);
    tick();
    total++; if (pc !== 32'h200) $display("FAIL empty_ret got %h want %h", pc, 32'h200); else passed++;
    drive(0, 0, 0, 1, 0, 32'h300);
    tick();
    drive(0, 0, 0, 1, 1, 32'h900);
    tick();
    total++; if (pc !== 32'h204) $display("FAIL callret_pc got %h want %h", pc, 32'h204); else passed++;
    drive(0, 0, 0, 0, 1, 32'h0);
    tick();
    total++; if (pc !== 32'h304) $display("FAIL callret_replaced got %h want %h", pc, 32'h304); else passed++;
    total++; if (ras_empty !== 1'b1) $display("FAIL callret_count got %b want 1", ras_empty); else passed++;
    drive(0, 0, 0, 0, 0, 0);
  endtask
`else
  task automatic test_no_ras;
    drive(0, 0, 0, 0, 1, 32'h60);
    tick();
    total++; if (pc !== 32'h60) $display("FAIL noras_ret got %h want %h", pc, 32'h60); else passed++;
    total++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) $display("FAIL noras_flags got %b%b want 10", ras_empty, ras_full); else passed++;
    drive(1, 0, 0, 1, 0, 32'h72);
    tick();
    total++; if (pc !== 32'h70) $display("FAIL noras_call got %h want %h", pc, 32'h70); else passed++;
    total++; if (misalign !== 1'b1) $display("FAIL noras_misalign got %b want 1", misalign); else passed++;
    total++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) $display("FAIL noras_flags2 got %b%b want 10", ras_empty, ras_full); else passed++;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++; if (pc !== 32'h74) $display("FAIL noras_seq got %h want %h", pc, 32'h74); else passed++;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_increment();
    test_redirect();
    test_wrap();
    test_trap();
`ifdef PC_RAS_EN
    test_ras();
`else
    test_no_ras();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
